mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the single-ported unified MEM between the multicycle CPU (port 0) and a loader/DMA engine (port 1).
- Round-robin grant with a bounded burst lock.
- Pipelined: one access issued per cycle; fixed read latency.
- Sits between the requesters and MEM; drives MEM's mem_addr, MemWrite and mem_write_data, and consumes mem_read_data.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is waiting (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req0_valid / req1_valid  in  1  request present
- req0_we / req1_we  in  1  1=write, 0=read
- req0_addr / req1_addr  in  ADDR_W  byte address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  read data valid, one-cycle pulse
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  to MEM
- MemWrite  out  1  to MEM
- mem_write_data  out  DATA_W  to MEM
- mem_read_data  in  DATA_W  from MEM (combinational read)

Behaviour:
- Reset values:
  - all outputs 0;
  - issue stage empty;
  - owner=port0, burst_cnt=0.
- Pipeline, 3 stages. For a request accepted in cycle t (reqN_valid & reqN_ready):
  - request latched at the edge ending t;
  - cycle t+1: mem_addr, MemWrite (=we) and mem_write_data driven from the latch; writes commit at the edge ending t+1;
  - read data registered at that same edge; rspN_valid=1 with rspN_rdata in cycle t+2.
  - Writes produce no response.
- Throughput: one acceptance per cycle, no bubbles. Idle issue stage: MemWrite=0, mem_addr holds its last value.
- Grant selection (combinational, each cycle):
  - exactly one readyN, or none;
  - only one valid: that port wins;
  - both valid: owner wins if burst_cnt < MAX_BURST, else the non-owner wins.
- Owner and burst tracking, on acceptance:
  - winner == owner: burst_cnt++ (saturates at MAX_BURST);
  - otherwise: owner←winner, burst_cnt←1.
  - When the non-owner is idle, the owner keeps being granted past MAX_BURST; the counter saturates and does not wrap.
- Ordering:
  - responses return in acceptance order;
  - a read following a write to the same address sees the new data, because the write commits one edge earlier.
- Requesters must hold valid, we, addr and wdata stable until ready. Deasserting valid before ready is legal and drops the request.
- Reset mid-operation: the in-flight access is discarded, MemWrite drops to 0 immediately (asynchronously), and no response is delivered.

Optional Feature:
- Macro MEM_PORT_ARBITER_STATS_EN.
- Defined: adds outputs grant0_cnt[15:0], grant1_cnt[15:0] and conflict_cnt[15:0].
  - grantN_cnt counts acceptances per port.
  - conflict_cnt counts cycles where both ports are valid.
  - All three are saturating at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg: port-ID constants PORT_CPU=0 and PORT_DMA=1; the issue-stage valid encoding.
- One sub-module, arb_rr_burst: owner register, burst counter and winner logic. Outputs grant0/grant1; input accept.
- Top level: pipeline registers and MEM muxing.

Test Plan:
- Single read:
  - stimulus: MEM[0x40]=0xDEADBEEF; req0 read 0x40 at cycle 2;
  - response: req0_ready in cycle 2; mem_addr=0x40 in cycle 3; rsp0_valid=1 with rdata=0xDEADBEEF in cycle 4 only.
- Write then read back:
  - stimulus: req1 writes 0x12345678 to 0x80 in cycle t, then reads 0x80 in t+1;
  - response: MemWrite=1 only in t+1; rsp1_rdata=0x12345678 in t+3.
- Contention with MAX_BURST=4:
  - stimulus: both ports valid continuously for 10 cycles, owner=port0 after reset;
  - response: grant pattern 0,0,0,0,1,1,1,1,0,0.
- Single-port streaming:
  - stimulus: only port0 valid for 8 cycles;
  - response: ready every cycle, burst_cnt saturates at 4, 8 responses in order.
- Reset mid-access:
  - stimulus: assert rst during the issue cycle of a write;
  - response: MemWrite=0 asynchronously, MEM unchanged, no rsp pulse; after release, owner=port0.
- Stats (MEM_PORT_ARBITER_STATS_EN defined):
  - stimulus: run the contention test;
  - response: conflict_cnt=10, grant0_cnt=6, grant1_cnt=4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the MEM port arbiter: requester port IDs and the
// encoding of what the issue stage currently holds.
package mem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Issue-stage content encoding
  localparam logic [1:0] ISS_IDLE  = 2'b00;
  localparam logic [1:0] ISS_READ  = 2'b01;
  localparam logic [1:0] ISS_WRITE = 2'b10;

endpackage

// File: rtl/arb_rr_burst.sv
// Round-robin winner selection with a bounded burst lock. The owner keeps
// winning contention until it has taken MAX_BURST consecutive grants; an
// uncontended owner keeps being granted and the counter saturates.
module arb_rr_burst
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             winner;

  // Pick the winner: a lone requester always wins, contention honours the burst lock
  always_comb begin
    winner = owner;
    if (valid0 && valid1) begin
      winner = (burst_cnt < CNT_MAX) ? owner : ~owner;
    end else if (valid0) begin
      winner = PORT_CPU;
    end else if (valid1) begin
      winner = PORT_DMA;
    end
    grant0 = (valid0 | valid1) & (winner == PORT_CPU);
    grant1 = (valid0 | valid1) & (winner == PORT_DMA);
  end

  // Track the owner and how many back-to-back grants it has taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= PORT_CPU;
      burst_cnt <= '0;
    end else if (accept) begin
      if (winner == owner) begin
        if (burst_cnt != CNT_MAX) begin
          burst_cnt <= burst_cnt + CNT_ONE;
        end
      end else begin
        owner     <= winner;
        burst_cnt <= CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-ported unified MEM.
// Port 0 is the CPU, port 1 the loader/DMA engine. One access issues per
// cycle; read data returns two cycles after acceptance, in order.
// Optional build macro MEM_PORT_ARBITER_STATS_EN adds saturating grant and
// conflict counters as extra outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              MemWrite,
  output logic [DATA_W-1:0] mem_write_data,
`ifdef MEM_PORT_ARBITER_STATS_EN
  output logic [15:0]       grant0_cnt,
  output logic [15:0]       grant1_cnt,
  output logic [15:0]       conflict_cnt,
`endif
  input  logic [DATA_W-1:0] mem_read_data
);

  logic              grant0, grant1, accept;
  logic              sel_port, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [1:0]        iss_kind_p0;
  logic              iss_port_p0;
  logic [ADDR_W-1:0] iss_addr_p0;
  logic [DATA_W-1:0] iss_wdata_p0;
  logic              iss_rd;

  logic              vld0_p1, vld1_p1;
  logic [DATA_W-1:0] rdata0_p1, rdata1_p1;

  arb_rr_burst #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (accept),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Steer the granted request toward the issue stage
  always_comb begin
    accept    = (req0_valid & grant0) | (req1_valid & grant1);
    sel_port  = grant1 ? PORT_DMA : PORT_CPU;
    sel_we    = grant1 ? req1_we    : req0_we;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---- stage p0: issue latch, drives MEM during the cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_kind_p0  <= ISS_IDLE;
      iss_port_p0  <= PORT_CPU;
      iss_addr_p0  <= '0;
      iss_wdata_p0 <= '0;
    end else begin
      iss_kind_p0 <= accept ? (sel_we ? ISS_WRITE : ISS_READ) : ISS_IDLE;
      if (accept) begin
        iss_port_p0  <= sel_port;
        iss_addr_p0  <= sel_addr;
        iss_wdata_p0 <= sel_wdata;
      end
    end
  end

  assign mem_addr       = iss_addr_p0;
  assign MemWrite       = (iss_kind_p0 == ISS_WRITE);
  assign mem_write_data = iss_wdata_p0;
  assign iss_rd         = (iss_kind_p0 == ISS_READ);

  // ---- stage p1: capture read data for the port that issued the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
    end else begin
      vld0_p1 <= iss_rd & (iss_port_p0 == PORT_CPU);
      vld1_p1 <= iss_rd & (iss_port_p0 == PORT_DMA);
      if (iss_rd && (iss_port_p0 == PORT_CPU)) rdata0_p1 <= mem_read_data;
      if (iss_rd && (iss_port_p0 == PORT_DMA)) rdata1_p1 <= mem_read_data;
    end
  end

  assign rsp0_valid = vld0_p1;
  assign rsp0_rdata = rdata0_p1;
  assign rsp1_valid = vld1_p1;
  assign rsp1_rdata = rdata1_p1;

`ifdef MEM_PORT_ARBITER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count acceptances per port and cycles in which both ports compete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_valid && grant0) grant0_cnt <= sat_inc16(grant0_cnt);
      if (req1_valid && grant1) grant1_cnt <= sat_inc16(grant1_cnt);
      if (req0_valid && req1_valid) conflict_cnt <= sat_inc16(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural MEM, a cycle-level model of the
// arbitration rules and pipeline timing, and directed scenarios with literal
// expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req0_we = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_wdata = '0;
  logic              req1_valid = 1'b0, req1_we = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_wdata = '0;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              MemWrite;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0]       grant0_cnt, grant1_cnt, conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rsp0_seen = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_we        (req0_we),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_we        (req1_we),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_ready     (req1_ready),
    .rsp0_valid     (rsp0_valid),
    .rsp0_rdata     (rsp0_rdata),
    .rsp1_valid     (rsp1_valid),
    .rsp1_rdata     (rsp1_rdata),
    .mem_addr       (mem_addr),
    .MemWrite       (MemWrite),
    .mem_write_data (mem_write_data),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .grant0_cnt     (grant0_cnt),
    .grant1_cnt     (grant1_cnt),
    .conflict_cnt   (conflict_cnt),
`endif
    .mem_read_data  (mem_read_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i));
  endfunction

  // Behavioural single-ported MEM: combinational read, write at clock edge
  logic [31:0] mem [256];
  assign mem_read_data = mem[mem_addr[9:2]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
    forever begin
      @(posedge clk);
      if (MemWrite) mem[mem_addr[9:2]] <= mem_write_data;
    end
  end

  // Reference model and per-cycle compare
  initial begin
    logic [31:0] mdl_mem [256];
    int          owner, cnt, g;
    bit          iss_v, iss_we;
    int          iss_port;
    logic [31:0] iss_addr, iss_wdata, last_addr;
    bit          rsp_v [2];
    logic [31:0] rsp_d [2];
    for (int i = 0; i < 256; i++) mdl_mem[i] = mem_init(i);
    owner = 0; cnt = 0; iss_v = 0; iss_we = 0; iss_port = 0;
    iss_addr = 0; iss_wdata = 0; last_addr = 0;
    rsp_v[0] = 0; rsp_v[1] = 0; rsp_d[0] = 0; rsp_d[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = 0; cnt = 0; iss_v = 0; last_addr = 0;
        rsp_v[0] = 0; rsp_v[1] = 0;
        check("rst_memwrite", MemWrite, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rdata", rsp0_rdata | rsp1_rdata, 0);
        continue;
      end
      g = -1;
      if (req0_valid && req1_valid) g = (cnt < MAX_BURST) ? owner : 1 - owner;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      check("ready0", req0_ready, (g == 0));
      check("ready1", req1_ready, (g == 1));
      check("memwrite", MemWrite, (iss_v && iss_we));
      check("mem_addr", mem_addr, last_addr);
      if (iss_v && iss_we) check("mem_wdata", mem_write_data, iss_wdata);
      check("rsp0_valid", rsp0_valid, rsp_v[0]);
      check("rsp1_valid", rsp1_valid, rsp_v[1]);
      if (rsp_v[0]) check("rsp0_rdata", rsp0_rdata, rsp_d[0]);
      if (rsp_v[1]) check("rsp1_rdata", rsp1_rdata, rsp_d[1]);
      if (rsp0_valid) rsp0_seen++;
      // advance to the next cycle
      rsp_v[0] = iss_v && !iss_we && iss_port == 0;
      rsp_v[1] = iss_v && !iss_we && iss_port == 1;
      if (iss_v && !iss_we) rsp_d[iss_port] = mdl_mem[iss_addr[9:2]];
      if (iss_v && iss_we) mdl_mem[iss_addr[9:2]] = iss_wdata;
      if (g >= 0) begin
        iss_v     = 1;
        iss_port  = g;
        iss_we    = (g == 1) ? req1_we : req0_we;
        iss_addr  = (g == 1) ? req1_addr : req0_addr;
        iss_wdata = (g == 1) ? req1_wdata : req0_wdata;
        last_addr = iss_addr;
        if (g == owner) cnt = (cnt < MAX_BURST) ? cnt + 1 : MAX_BURST;
        else begin owner = g; cnt = 1; end
      end else begin
        iss_v = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic [9:0]  pat;
    logic [31:0] a0, a1;
    int          base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("init_memwrite", MemWrite, 0);
    check("init_mem_addr", mem_addr, 0);
    check("init_rsp0", rsp0_valid, 0);
    check("init_rsp1", rsp1_valid, 0);

    // Contention: both ports continuously valid for 10 cycles
    a0 = 32'h100; a1 = 32'h200; pat = '0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = a0;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = a1;
      @(negedge clk);
      pat[i] = req1_ready;
      if (req0_ready) a0 = a0 + 32'd4;
      if (req1_ready) a1 = a1 + 32'd4;
      cyc();
    end
    idle();
    check("contention_pattern", {22'd0, pat}, 32'b0011110000);
`ifdef MEM_PORT_ARBITER_STATS_EN
    check("stats_conflict", {16'd0, conflict_cnt}, 10);
    check("stats_grant0", {16'd0, grant0_cnt}, 6);
    check("stats_grant1", {16'd0, grant1_cnt}, 4);
`endif
    repeat (3) cyc();

    // Single read of 0x40
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h40;
    @(negedge clk);
    check("rd_ready", req0_ready, 1);
    cyc(); idle();
    check("rd_mem_addr", mem_addr, 32'h40);
    check("rd_memwrite", MemWrite, 0);
    cyc();
    check("rd_rsp_valid", rsp0_valid, 1);
    check("rd_rsp_data", rsp0_rdata, 32'hDEADBEEF);
    cyc();
    check("rd_rsp_pulse", rsp0_valid, 0);
    cyc();

    // Write then read back on port 1
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h80; req1_wdata = 32'h12345678;
    check("wr_memwrite_t", MemWrite, 0);
    cyc();
    check("wr_memwrite_t1", MemWrite, 1);
    req1_we = 1'b0;
    cyc(); idle();
    check("wr_memwrite_t2", MemWrite, 0);
    cyc();
    check("wr_rsp_valid", rsp1_valid, 1);
    check("wr_rsp_data", rsp1_rdata, 32'h12345678);
    repeat (2) cyc();

    // Port 0 streaming, 8 reads
    base = rsp0_seen;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h300 + 32'(4 * i);
      @(negedge clk);
      check("stream_ready", req0_ready, 1);
      cyc();
    end
    // Saturated burst counter: a waiting port 1 must win at once
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h3E0;
    @(negedge clk);
    check("sat_ready1", req1_ready, 1);
    cyc(); req1_valid = 1'b0;
    cyc(); idle();
    repeat (3) cyc();
    check("stream_rsp_count", rsp0_seen - base, 9);

    // Reset during the issue cycle of a port-1 write
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h3F0; req1_wdata = 32'hCAFEF00D;
    cyc(); idle();
    check("rst_issue_memwrite", MemWrite, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_memwrite", MemWrite, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mem_unchanged", mem[252], mem_init(252));
    check("rst_no_rsp", rsp1_valid, 0);
    cyc();
    check("rst_no_rsp_late", rsp1_valid, 0);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h14;
    @(negedge clk);
    check("rst_owner_ready0", req0_ready, 1);
    check("rst_owner_ready1", req1_ready, 0);
    cyc(); idle();
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
